reset_sequencer: RTL

Parametrised reset controller for one clock domain. It is asserted asynchronously and deasserted synchronously through a configurable-depth synchroniser. After deassert it holds reset for a minimum stretch, then releases NUM_RESETS active-low reset outputs one at a time with a fixed spacing. It also accepts a synchronous software reset request that re-runs the full sequence. It sits at the top of each clock domain and feeds the per-subsystem resets.

---
 rtl/reset_sequencer_if.sv | 23 ++
 rtl/reset_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - software request and sequenced reset fan-out bundle
interface reset_sequencer_if #(
  parameter int NUM_RESETS = 4
);
  logic                  sw_rst_req;
  logic [NUM_RESETS-1:0] rst_n_out;
  logic                  rst_done;
  logic                  last_cause;

  modport master (
    input  sw_rst_req,
    output rst_n_out,
    output rst_done,
    output last_cause
  );

  modport slave (
    output sw_rst_req,
    input  rst_n_out,
    input  rst_done,
    input  last_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - async-assert/sync-deassert reset controller with staged release
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_RESETS  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  reset_sequencer_if.master         bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [NUM_RESETS-1:0] FIRST_BIT = NUM_RESETS'(1);
  localparam logic [NUM_RESETS-1:0] ALL_ONES  = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (NUM_RESETS < 1) begin : g_bad_num
    $error("reset_sequencer: NUM_RESETS must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("reset_sequencer: STEP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_RESETS-1:0]  rst_n_q, rst_n_d;
  logic                   done_q, done_d;
  logic                   cause_q, cause_d;

  // Deassertion ripples a constant 1 through the chain; assertion clears it at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    cause_d = cause_q;

    if (sync_n && bus.sw_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
      cause_d = 1'b1;
    end else if (sync_n) begin
      case (state_q)
        HOLD, RELEASE: begin
          if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : STEP_LAST)) begin
            // Shifting in a 1 keeps the released bits contiguous from bit 0.
            rst_n_d = (rst_n_q << 1) | FIRST_BIT;
            cnt_d   = '0;
            if (rst_n_d == ALL_ONES) begin
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_n_out  = rst_n_q;
  assign bus.rst_done   = done_q;
  assign bus.last_cause = cause_q;

endmodule
